// File: rtl/hs_pkg.sv
// Shared constants and helpers for the hs FIFO slice.
package hs_pkg;

    localparam int HS_DATA_WIDTH = 16;

    // Pointer carries one extra bit above the index to tell full from empty.
    function automatic int hs_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module hs_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/hs_sync_fifo.sv
// Single-clock first-word fall-through FIFO with valid/ready on both sides,
// almost-full flag and sticky overflow flag.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH  = HS_DATA_WIDTH,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [DATA_WIDTH-1:0]           o_rdata,
    output logic [hs_ptr_width(DEPTH)-1:0]  o_count,
    output logic                            o_afull,
    output logic                            o_ovf
);

    localparam int PW = hs_ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          ovf_q,  ovf_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Status comes only from registered pointers, so i_ready never sees o_ready.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[PW-1] != rptr_q[PW-1]);
    assign o_count = wptr_q - rptr_q;
    assign i_ready = !full;
    assign o_valid = !empty;
    assign o_afull = (o_count >= PW'(AFULL_LEVEL));
    assign o_ovf   = ovf_q;

    assign push = i_valid && i_ready;
    assign pop  = o_valid && o_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (i_valid && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wptr_q[AW-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (rptr_q[AW-1:0]),
        .o_rdata (o_rdata)
    );

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Bench for hs_sync_fifo: queue model checked every cycle plus directed literal checks.
module tb_hs_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk;
    logic          i_rstn;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_wdata;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_rdata;
    logic [CW-1:0] o_count;
    logic          o_afull;
    logic          o_ovf;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q [$];
    logic          m_ovf = 1'b0;

    hs_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_wdata (i_wdata),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_rdata (o_rdata),
        .o_count (o_count),
        .o_afull (o_afull),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy is queue size; pushes refused when full, pops ignored when empty.
    always @(posedge i_clk) begin
        if (i_rstn) begin
            int  n;
            logic do_push, do_pop;
            n       = q.size();
            do_push = i_valid && (n != DEPTH);
            do_pop  = o_ready && (n != 0);
            if (i_valid && n == DEPTH) m_ovf = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(i_wdata);
        end
    end

    always @(negedge i_rstn) begin
        q.delete();
        m_ovf = 1'b0;
    end

    always @(negedge i_clk) begin
        chk("m_count",  32'(o_count), 32'(q.size()));
        chk("m_valid",  32'(o_valid), 32'(q.size() != 0));
        chk("m_ready",  32'(i_ready), 32'(q.size() != DEPTH));
        chk("m_afull",  32'(o_afull), 32'(q.size() >= AFULL));
        chk("m_ovf",    32'(o_ovf),   32'(m_ovf));
        chk("m_maxcnt", 32'(o_count <= CW'(DEPTH)), 32'd1);
        if (q.size() != 0) chk("m_rdata", 32'(o_rdata), 32'(q[0]));
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_wdata = '0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(i_ready), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_afull", 32'(o_afull), 32'd0);
        chk("rst_ovf",   32'(o_ovf),   32'd0);
        cyc(); cyc();
        i_rstn = 1'b1;
        cyc();

        // Single word, fall-through latency and stall hold.
        i_valid = 1'b1; i_wdata = 16'h1234;
        chk("lat_before", 32'(o_valid), 32'd0);
        cyc();
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("one_valid", 32'(o_valid), 32'd1);
            chk("one_rdata", 32'(o_rdata), 32'h1234);
            chk("one_count", 32'(o_count), 32'd1);
            cyc();
        end
        o_ready = 1'b1;
        cyc();
        o_ready = 1'b0;
        chk("one_empty", 32'(o_valid), 32'd0);

        // Fill to full, then overflow attempt.
        for (int k = 0; k < DEPTH; k++) begin
            i_valid = 1'b1; i_wdata = 16'(k);
            cyc();
            chk("fill_count", 32'(o_count), 32'(k + 1));
            chk("fill_afull", 32'(o_afull), 32'((k + 1) >= 6));
            chk("fill_ready", 32'(i_ready), 32'((k + 1) != 8));
        end
        chk("pre_ovf", 32'(o_ovf), 32'd0);
        i_wdata = 16'h00FF;
        cyc();
        chk("ovf_set",   32'(o_ovf),   32'd1);
        chk("ovf_count", 32'(o_count), 32'd8);
        chk("ovf_head",  32'(o_rdata), 32'h0000);

        // Full with push and pop together: pop wins, push refused.
        i_wdata = 16'h00AA; o_ready = 1'b1;
        cyc();
        i_valid = 1'b0;
        chk("fullpp_count", 32'(o_count), 32'd7);
        chk("fullpp_head",  32'(o_rdata), 32'h0001);
        chk("fullpp_ready", 32'(i_ready), 32'd1);

        // Drain to three entries (5,6,7 remain).
        repeat (4) cyc();
        chk("drain_count", 32'(o_count), 32'd3);
        chk("drain_head",  32'(o_rdata), 32'h0005);

        // Continuous push/pop across pointer wrap.
        i_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_wdata = 16'h0100 + 16'(k);
            cyc();
            chk("stream_count", 32'(o_count), 32'd3);
        end
        chk("stream_head", 32'(o_rdata), 32'h0111);

        // Build to five, then reset mid-cycle.
        o_ready = 1'b0;
        i_wdata = 16'h0200; cyc();
        i_wdata = 16'h0201; cyc();
        i_valid = 1'b0;
        chk("pre_rst_count", 32'(o_count), 32'd5);
        #3;
        i_rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        chk("mid_rst_ovf",   32'(o_ovf),   32'd0);
        chk("mid_rst_ready", 32'(i_ready), 32'd1);
        cyc();
        i_rstn = 1'b1;
        cyc();
        i_valid = 1'b1; i_wdata = 16'hBEEF;
        cyc();
        i_valid = 1'b0;
        chk("post_rst_head",  32'(o_rdata), 32'hBEEF);
        chk("post_rst_count", 32'(o_count), 32'd1);
        o_ready = 1'b1;
        cyc();
        chk("post_rst_empty", 32'(o_valid), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 10000; k++) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            i_wdata = 16'($urandom);
            cyc();
        end
        i_valid = 1'b0; o_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        chk("final_empty", 32'(o_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_sync_fifo.md
HS_SYNC_FIFO -- requirements
Module: hs_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_LEVEL, default 6, occupancy at or above which o_afull asserts; range 1..DEPTH.
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge; one clock, all logic in this domain.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_valid  input  1  upstream word present.
REQ-007 SHALL have port i_ready  output  1  FIFO can accept a word.
REQ-008 SHALL have port i_wdata  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port o_valid  output  1  head word present.
REQ-010 SHALL have port o_ready  input  1  downstream accepts head word.
REQ-011 SHALL have port o_rdata  output  DATA_WIDTH  head payload.
REQ-012 SHALL have port o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port o_afull  output  1  o_count >= AFULL_LEVEL.
REQ-014 SHALL have port o_ovf  output  1  sticky flag: i_valid seen while full.

Function
REQ-015 SHALL push i_wdata on a rising edge when i_valid && i_ready; SHALL pop when o_valid && o_ready.
REQ-016 SHALL drive i_ready = (o_count != DEPTH), registered-state only, with no combinational path from o_ready.
REQ-017 SHALL drive o_valid = (o_count != 0), first-word fall-through: o_rdata equals the head entry whenever o_valid=1.
REQ-018 SHALL present a word on o_valid exactly 1 cycle after its push edge when empty (latency 1).
REQ-019 SHALL hold o_rdata and o_valid stable while o_valid=1 and o_ready=0.
REQ-020 SHALL deliver words in push order with no loss or duplication.
REQ-021 SHALL, on simultaneous push and pop at 0 < count < DEPTH, leave o_count unchanged and advance both pointers.
REQ-022 SHALL, when full, refuse the push even if a pop occurs in the same cycle; o_count becomes DEPTH-1.
REQ-023 SHALL, when empty, ignore o_ready; no pop, pointers unchanged.
REQ-024 SHALL use read/write pointers of $clog2(DEPTH)+1 bits; index = low bits, MSB = wrap flag; full = indices equal, MSBs differ; empty = pointers equal.
REQ-025 SHALL wrap pointers modulo 2*DEPTH without a discontinuity at the wrap point.
REQ-026 SHALL set o_ovf when i_valid=1 and o_count=DEPTH at a rising edge; o_ovf clears only on reset.
REQ-027 SHALL update o_afull from the registered count (no lookahead).

Reset
REQ-028 SHALL, on i_rstn low, asynchronously clear both pointers, o_count and o_ovf, giving o_valid=0, i_ready=1 and o_afull=0.
REQ-029 SHALL leave storage contents unreset; o_rdata is don't-care while o_valid=0.
REQ-030 SHALL discard all stored words on reset mid-operation; the first post-reset push is the first word delivered.

Structure
REQ-031 SHALL take the DATA_WIDTH default and the pointer-width helper constant from the shared package hs_pkg.
REQ-032 SHALL place the storage array (write port, async read, no reset) in sub-module hs_fifo_mem; pointer and flag logic stay in hs_sync_fifo.

Verification
REQ-033 Bench SHALL cover: reset, push 0x1234 with o_ready=0 -> next cycle o_valid=1, o_rdata=0x1234, o_count=1, held while stalled.
REQ-034 Bench SHALL cover: DEPTH=8, push 0x0000..0x0007 with o_ready=0 -> i_ready=0 after 8th, o_afull=1 from count 6; extra i_valid -> o_ovf=1.
REQ-035 Bench SHALL cover: full, i_valid=1 and o_ready=1 for one cycle -> 0x0000 popped, push refused, o_count=7.
REQ-036 Bench SHALL cover: count=3, continuous push/pop for 20 cycles -> o_count stays 3, in-order data across pointer wrap.
REQ-037 Bench SHALL cover: count=5, i_rstn pulsed low mid-cycle -> immediate o_valid=0, o_count=0, o_ovf=0; next push 0xBEEF emerges first.
REQ-038 Bench SHALL cover: random i_valid/o_ready 10000 cycles vs. scoreboard -> zero mismatches, o_count never exceeds 8.
